// File: rtl/alu_arbiter.sv
// Round-robin sequencer that shares one external combinational 8-bit ALU among
// NUM_REQ requesters, returning each result with the owner's ID over valid/ready.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_a_i,
    input  logic [8*NUM_REQ-1:0]   req_b_i,
    input  logic [3*NUM_REQ-1:0]   req_op_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             alu_a_o,
    output logic [7:0]             alu_b_o,
    output logic [2:0]             alu_op_o,
    input  logic [7:0]             alu_res_i,
    output logic                   rsp_valid_o,
    output logic [7:0]             rsp_data_o,
    output logic [ID_W-1:0]        rsp_id_o,
    input  logic                   rsp_ready_i,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic [7:0]      sel_a;
    logic [7:0]      sel_b;
    logic [2:0]      sel_op;
    logic [7:0]      opa;
    logic [7:0]      opb;
    logic [2:0]      opc;
    logic [7:0]      res;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the unused fourth encoding falls back to IDLE.
    always_comb begin
        // NOTE: assigning a default before the case keeps this block free of
        // inferred latches even when a branch forgets to assign.
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = grant_found ? EXEC : IDLE;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = rsp_ready_i ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Rotating priority: first pass covers indices at or above ptr, second
    // pass wraps around to the indices below it.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_a       = '0;
        sel_b       = '0;
        sel_op      = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (!grant_found && req_valid_i[n] && n >= int'(ptr)) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(n);
                sel_a       = req_a_i[n*8 +: 8];
                sel_b       = req_b_i[n*8 +: 8];
                sel_op      = req_op_i[n*3 +: 3];
            end
        end
        for (int n = 0; n < NUM_REQ; n++) begin
            if (!grant_found && req_valid_i[n] && n < int'(ptr)) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(n);
                sel_a       = req_a_i[n*8 +: 8];
                sel_b       = req_b_i[n*8 +: 8];
                sel_op      = req_op_i[n*3 +: 3];
            end
        end
    end

    // Output logic; ready is masked during reset so no handshake can complete.
    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && grant_found && !reset) begin
            req_ready_o[grant_idx] = 1'b1;
        end
        rsp_valid_o = (state == RESP);
        busy_o      = (state != IDLE);
    end

    // Operand capture on grant, result capture in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            win <= '0;
            opa <= '0;
            opb <= '0;
            opc <= '0;
            res <= '0;
        end else begin
            if (state == IDLE && grant_found) begin
                opa <= sel_a;
                opb <= sel_b;
                opc <= sel_op;
                win <= grant_idx;
                ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
            if (state == EXEC) begin
                res <= alu_res_i;
            end
        end
    end

    // win only changes on a grant in IDLE, so it doubles as the response ID.
    assign alu_a_o    = opa;
    assign alu_b_o    = opb;
    assign alu_op_o   = opc;
    assign rsp_data_o = res;
    assign rsp_id_o   = win;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational 8-bit ALU (`a_i`, `b_i`, `op_i[2:0]` in, `alu_o` out) among `NUM_REQ` requesters. It accepts one request at a time over a valid/ready handshake and registers the operands into the ALU. It captures the ALU result and returns it with the requester ID over a valid/ready response channel. It sits between the requesting engines and the ALU instance; the ALU itself is not part of this block.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID. Derived; do not override.

Ports (reset is synchronous and active-high; single clock):
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  request pending, one bit per requester.
- `req_a_i`  in  8*NUM_REQ  operand A; requester n occupies bits [8n+7:8n].
- `req_b_i`  in  8*NUM_REQ  operand B, packed the same way.
- `req_op_i`  in  3*NUM_REQ  ALU opcode; requester n occupies bits [3n+2:3n].
- `req_ready_o`  out  NUM_REQ  one-hot accept; at most one bit high per cycle.
- `alu_a_o`  out  8  to ALU `a_i`.
- `alu_b_o`  out  8  to ALU `b_i`.
- `alu_op_o`  out  3  to ALU `op_i`.
- `alu_res_i`  in  8  from ALU `alu_o` (combinational).
- `rsp_valid_o`  out  1  response available.
- `rsp_data_o`  out  8  registered ALU result.
- `rsp_id_o`  out  ID_W  index of the requester that owns the response.
- `rsp_ready_i`  in  1  consumer accepts the response.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. It encodes as 2 bits; the fourth code recovers to IDLE.
- Registers: `ptr` (ID_W, round-robin start), `win` (ID_W), operand regs `opa`, `opb`, `opc`, result reg, state.
- **IDLE:**
  - If any `req_valid_i` bit is set, the winner is the first set bit found scanning upward from `ptr`, modulo NUM_REQ.
  - `req_ready_o[win]` is asserted combinationally in the same cycle.
  - At the clock edge:
    - latch that requester's A, B and op into `opa`/`opb`/`opc`;
    - store `win`;
    - set `ptr` to (win+1) mod NUM_REQ;
    - go to EXEC.
  - If no bit is set, stay in IDLE.
- **EXEC:** `alu_*_o` are driven by `opa`/`opb`/`opc`. At the clock edge, register `alu_res_i` into `rsp_data_o`, set `rsp_id_o` to `win`, set `rsp_valid_o`, and go to RESP.
- **RESP:**
  - Hold `rsp_valid_o`, `rsp_data_o` and `rsp_id_o` stable until `rsp_ready_i` is high.
  - On that edge, clear `rsp_valid_o` and go to IDLE.
  - `req_ready_o` is 0 throughout.
- `req_ready_o` is all-zero outside IDLE.
- `alu_*_o` always reflect the operand registers and hold their last values between operations.
- Requesters must hold their valid and operands stable until ready. A requester may withdraw valid before it is granted; no state is affected.
- No arithmetic is done in this block. The result is the ALU output bit-for-bit, including 8-bit wrap-around. The ALU opcode 3'b000 is ADD.
- Simultaneous events:
  - A new request arriving while the block is busy waits; it is never dropped or queued internally.
  - A request and `rsp_ready_i` in the same RESP cycle: the request is granted no earlier than the following IDLE cycle.

## Timing
- Reset values: state IDLE, `ptr`=0, `win`=0, operand regs 0, `alu_a_o`/`alu_b_o`/`alu_op_o`=0, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_id_o`=0, `req_ready_o`=0, `busy_o`=0.
- Reset mid-operation (EXEC or RESP) abandons the operation. No response is produced and the next cycle shows all reset values.
- Reset has priority over every handshake in the same cycle.
- Latency: a grant in cycle T (ready high at T) gives the operands on `alu_*_o` at T+1 and `rsp_valid_o` high at T+2.
- With `rsp_ready_i` held high, RESP lasts one cycle and the next grant can occur at T+3. Peak throughput is one operation per 3 cycles.
- No combinational path from `rsp_ready_i` to any output. `req_ready_o` depends combinationally on `req_valid_i`, `ptr` and state only.

## Test plan
- **Reset:** hold `reset` 2 cycles with all `req_valid_i` high -> `req_ready_o`=0, `rsp_valid_o`=0, `alu_*_o`=0 and `busy_o`=0 during reset. First grant is to requester 0 in the first cycle after reset.
- **Single request:** requester 2 sends A=0x05, B=0x03, op=3'b000 at T with `rsp_ready_i`=1 -> `req_ready_o`=4'b0100 at T; `alu_a_o`=0x05 at T+1; at T+2 `rsp_valid_o`=1, `rsp_data_o`=0x08, `rsp_id_o`=2; `busy_o` low at T+3.
- **Fairness:** all four requesters continuously valid, `rsp_ready_i`=1 -> grant order 0,1,2,3,0,1, with grants exactly 3 cycles apart.
- **Pointer wrap and arithmetic wrap:**
  - After a grant to requester 3, requesters 0 and 3 are valid -> requester 0 wins.
  - Requester 0 sends A=0xFF, B=0x01, ADD -> `rsp_data_o`=0x00.
- **Backpressure:** `rsp_ready_i` held low 5 cycles in RESP -> `rsp_valid_o`, `rsp_data_o` and `rsp_id_o` stay constant, `req_ready_o` stays 0 while others are valid. The next grant follows one cycle after `rsp_ready_i` rises.
- **Reset mid-op:** assert `reset` for 1 cycle in EXEC, with requester 1 having been granted -> no `rsp_valid_o` pulse, `ptr` returns to 0, and the next grant goes to the lowest valid index.
